// File: rtl/irq_controller.sv
// Interrupt controller: synchronised edge capture, per-source mask, fixed-priority select, held request.
// Latency: irq_in edge to pending is 2 clocks after first sample; pending to interrupt is 1 clock.
// Backpressure: a request stays asserted until ack; re-arming needs one ack-low cycle after service.
`timescale 1ns/1ps
module irq_controller #(
    parameter int N_SRC  = 4,
    parameter int ID_W   = 2,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [N_SRC-1:0]  mask,
    input  logic              ack,
    output logic              interrupt,
    output logic [ID_W-1:0]   irq_id,
    output logic [N_SRC-1:0]  pending,
    output logic [MISS_W-1:0] miss_count
);

    localparam int CNT_W = $clog2(N_SRC + 1);
    localparam int SUM_W = MISS_W + CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_SRC-1:0]  sync_s1, sync_s2, sync_prev;
    logic [N_SRC-1:0]  edge_det;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  clear;
    logic [N_SRC-1:0]  miss_vec;
    logic [N_SRC-1:0]  pending_nxt;
    logic [ID_W-1:0]   sel_id;
    logic              load_id;
    logic              svc_ack;
    logic [CNT_W-1:0]  miss_pop;
    logic [SUM_W-1:0]  miss_sum;
    logic [MISS_W-1:0] miss_nxt;

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            sync_prev <= '0;
        end else begin
            sync_s1   <= irq_in;
            sync_s2   <= sync_s1;
            sync_prev <= sync_s2;
        end
    end

    assign edge_det = sync_s2 & ~sync_prev;
    assign eligible = pending & ~mask;
    assign svc_ack  = (state == ST_REQ) && ack;

    // Descending scan so the lowest set index is the one left in sel_id.
    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        clear = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clear[i] = svc_ack && (irq_id == ID_W'(i));
        end
    end

    // A new edge wins over a same-cycle clear, and is not counted as a miss.
    assign miss_vec    = edge_det & pending & ~clear;
    assign pending_nxt = edge_det | (pending & ~clear);

    always_comb begin
        miss_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            miss_pop = miss_pop + CNT_W'(miss_vec[i]);
        end
    end

    always_comb begin
        miss_sum = SUM_W'(miss_count) + SUM_W'(miss_pop);
        miss_nxt = miss_sum[MISS_W-1:0];
        if (miss_sum > SUM_W'({MISS_W{1'b1}})) begin
            miss_nxt = {MISS_W{1'b1}};
        end
    end

    always_comb begin
        state_nxt = state;
        load_id   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    load_id   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            interrupt  <= 1'b0;
            irq_id     <= '0;
            pending    <= '0;
            miss_count <= '0;
        end else begin
            state      <= state_nxt;
            interrupt  <= (state_nxt == ST_REQ);
            pending    <= pending_nxt;
            miss_count <= miss_nxt;
            if (load_id) begin
                irq_id <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of the request/service rules.
`timescale 1ns/1ps
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_in = '0;
    logic [3:0] mask = '0;
    logic       ack = 1'b0;
    logic       interrupt;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [7:0] miss_count;

    irq_controller #(.N_SRC(4), .ID_W(2), .MISS_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask       (mask),
        .ack        (ack),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .pending    (pending),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: irq_in seen through a 3-deep sample history, a service
    // status (requesting / waiting for ack release / free), pending set and miss total.
    logic [3:0] hist [3];
    logic [3:0] m_pend = '0;
    int         m_miss = 0;
    bit         m_int  = 1'b0;
    int         m_id   = 0;
    bit         m_hold = 1'b0;
    logic [3:0] m_edge, m_clr;
    int         m_cnt;

    task automatic model_reset();
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        m_pend = '0; m_miss = 0; m_int = 1'b0; m_id = 0; m_hold = 1'b0;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            m_edge = hist[1] & ~hist[2];
            m_clr  = '0;
            if (m_int && ack) m_clr[m_id] = 1'b1;
            if (m_int) begin
                if (ack) begin m_int = 1'b0; m_hold = 1'b1; end
            end else if (m_hold) begin
                if (!ack) m_hold = 1'b0;
            end else if ((m_pend & ~mask) != 4'b0) begin
                for (int i = 3; i >= 0; i--) if (m_pend[i] && !mask[i]) m_id = i;
                m_int = 1'b1;
            end
            m_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_edge[i]) begin
                    if (m_pend[i] && !m_clr[i]) m_cnt++;
                    m_pend[i] = 1'b1;
                end else if (m_clr[i]) begin
                    m_pend[i] = 1'b0;
                end
            end
            m_miss = (m_miss + m_cnt > 255) ? 255 : m_miss + m_cnt;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_in;
        end
    end

    always @(negedge clk) begin
        chk("model_interrupt", 32'(interrupt), 32'(m_int));
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_miss", 32'(miss_count), 32'(m_miss));
        if (m_int) chk("model_irq_id", 32'(irq_id), 32'(m_id));
    end

    task automatic wait_int(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (interrupt) ok = 1'b1;
        end
    endtask

    task automatic service();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        @(negedge clk);
        irq_in = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cnt_hi;

        @(negedge clk);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single request on source 2
        pulse(4'b0100);
        repeat (2) @(negedge clk);
        chk("single_pending_E2", 32'(pending), 32'h4);
        chk("single_int_E2", 32'(interrupt), 32'd0);
        @(negedge clk);
        chk("single_int_E3", 32'(interrupt), 32'd1);
        chk("single_id_E3", 32'(irq_id), 32'd2);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("single_int_after_ack", 32'(interrupt), 32'd0);
        chk("single_pending_after_ack", 32'(pending), 32'd0);
        repeat (3) @(negedge clk);

        // Priority: sources 3 and 1 together
        pulse(4'b1010);
        repeat (3) @(negedge clk);
        chk("prio_int_first", 32'(interrupt), 32'd1);
        chk("prio_id_first", 32'(irq_id), 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("prio_pending_left", 32'(pending), 32'h8);
        wait_int(10, ok);
        chk("prio_second_seen", 32'(ok), 32'd1);
        chk("prio_id_second", 32'(irq_id), 32'd3);
        service();

        // Mask holds source 0 off
        mask = 4'b0001;
        pulse(4'b0001);
        repeat (2) @(negedge clk);
        chk("mask_pending", 32'(pending), 32'h1);
        cnt_hi = 0;
        repeat (20) begin @(negedge clk); if (interrupt) cnt_hi++; end
        chk("mask_no_int", 32'(cnt_hi), 32'd0);
        mask = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("unmask_int", 32'(interrupt), 32'd1);
        chk("unmask_id", 32'(irq_id), 32'd0);
        service();

        // Ack held through service with another source pending
        pulse(4'b0101);
        repeat (3) @(negedge clk);
        chk("hold_id_first", 32'(irq_id), 32'd0);
        ack = 1'b1;
        cnt_hi = 0;
        repeat (10) begin @(negedge clk); if (interrupt) cnt_hi++; end
        chk("hold_no_reissue", 32'(cnt_hi), 32'd0);
        chk("hold_pending", 32'(pending), 32'h4);
        ack = 1'b0;
        wait_int(10, ok);
        chk("hold_second_seen", 32'(ok), 32'd1);
        chk("hold_id_second", 32'(irq_id), 32'd2);
        // Edge on the serviced source lands in the ack cycle
        pulse(4'b0100);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("simul_pending", 32'(pending), 32'h4);
        chk("simul_miss", 32'(miss_count), 32'd0);
        chk("simul_int", 32'(interrupt), 32'd0);
        wait_int(10, ok);
        chk("simul_reissue", 32'(ok), 32'd1);
        chk("simul_reissue_id", 32'(irq_id), 32'd2);
        service();

        // Miss counting and saturation on source 1
        pulse(4'b0010);
        wait_int(10, ok);
        chk("miss_first_seen", 32'(ok), 32'd1);
        chk("miss_first_id", 32'(irq_id), 32'd1);
        for (int k = 0; k < 300; k++) begin
            pulse(4'b0010);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("miss_saturated", 32'(miss_count), 32'd255);
        chk("miss_pending1", 32'(pending[1]), 32'd1);
        chk("miss_int_held", 32'(interrupt), 32'd1);

        // Asynchronous reset while requesting
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_interrupt", 32'(interrupt), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_miss", 32'(miss_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt_hi = 0;
        repeat (10) begin @(negedge clk); if (interrupt) cnt_hi++; end
        chk("arst_no_req", 32'(cnt_hi), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) irq_in = 4'($urandom());
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom());
            ack = ($urandom_range(0, 3) == 0);
        end
        irq_in = '0;
        ack = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt request controller that sits directly upstream of the processor's single interrupt/ack pair.
- Collects rising edges from N external request lines into a pending register and applies a per-source mask.
- Selects the lowest-index unmasked pending source, drives interrupt plus its ID to the processor, and holds both until ack.
- Counts requests lost to an already-pending source.

Parameters:
- N_SRC, 4, number of external request lines.
- ID_W, 2, width of irq_id; must satisfy 2^ID_W >= N_SRC.
- MISS_W, 8, width of the saturating lost-request counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_in  in  N_SRC  raw external request lines, asynchronous to clk.
- mask  in  N_SRC  1 = source blocked from selection; its pending bit is still recorded.
- ack  in  1  processor acknowledge, level.
- interrupt  out  1  request to the processor, registered.
- irq_id  out  ID_W  index of the source being requested; valid while interrupt=1.
- pending  out  N_SRC  current pending register.
- miss_count  out  MISS_W  saturating count of lost edges.

Behaviour:
- Reset (rst=0, asynchronous):
  - interrupt=0, irq_id=0, pending=0, miss_count=0.
  - Synchroniser and edge-detect flops = 0; FSM = IDLE.
  - Any in-flight request is discarded; no ack is required after reset.
- Input path: each irq_in bit passes through a 2-flop synchroniser (s1, s2) and a previous-value flop (prev). edge[i] = s2[i] & ~prev[i].
- Latency: irq_in rising, first sampled at clock edge E0:
  - s2 rises at E1.
  - pending[i] sets at E2.
  - interrupt=1 at E3, when the FSM is IDLE and the source is unmasked.
- Pending update, per bit, per cycle, in priority order:
  - edge[i] → set. If pending[i] was already 1 and is not being cleared this cycle, miss_count += 1, saturating at 2^MISS_W-1.
  - clear[i] (serviced, see REQ) with no edge[i] → clear.
  - edge and clear in the same cycle → bit stays 1 (new request retained); no miss counted.
  - Several bits with simultaneous misses count +1 each, i.e. the popcount of the missing bits, still saturating.
- FSM states:
  - IDLE: interrupt=0. If (pending & ~mask) != 0, latch irq_id = lowest set index and go to REQ; interrupt=1 from the next cycle. ack is ignored in IDLE.
  - REQ: interrupt=1; irq_id held. Mask changes do not retract the request. When ack=1: assert clear[irq_id] this cycle, drive interrupt=0 at the next edge, go to WAIT.
  - WAIT: interrupt=0. Stay until ack=0, then go to IDLE. A new request therefore needs at least one ack-low cycle; an ack held high never double-services.
- Arbitration: fixed priority; index 0 is highest. Selection happens only in IDLE, so no pre-emption occurs.
- Masked pending bits stay set and become eligible the first IDLE cycle after they are unmasked.
- irq_id keeps its last value after service (it is not cleared) and is only meaningful while interrupt=1.

Test Plan:
- Single request:
  - Stimulus: rst low 2 cycles, then release; pulse irq_in[2] high for 1 cycle.
  - Response: pending=4'b0100 at E2; interrupt=1, irq_id=2 at E3.
  - Stimulus: ack=1 for 1 cycle.
  - Response: interrupt=0 and pending=0 the next cycle; FSM returns to IDLE after ack falls.
- Priority:
  - Stimulus: irq_in[3] and irq_in[1] rise in the same cycle.
  - Response: irq_id=1 is serviced first; after ack high then low, interrupt reasserts with irq_id=3.
- Mask:
  - Stimulus: mask=4'b0001, edge on irq_in[0].
  - Response: pending[0]=1, interrupt stays 0 for 20 cycles.
  - Stimulus: set mask=0.
  - Response: interrupt=1, irq_id=0 one cycle later.
- Miss and saturation:
  - Stimulus: hold ack=0 with irq_in[1] pending; apply 300 further edges on irq_in[1].
  - Response: miss_count=255 (saturated); pending[1]=1.
- Ack held and simultaneous events:
  - Stimulus: keep ack high through service, with irq_in[0] already pending.
  - Response: no new interrupt until ack=0.
  - Stimulus: an edge on the serviced source in the ack cycle.
  - Response: pending bit remains 1; miss_count unchanged.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously while in REQ with interrupt=1.
  - Response: interrupt, pending and miss_count go to 0 immediately, without waiting for a clock edge; after release, no request until a fresh edge arrives.
